// File: rtl/intr_ctrl.sv
// intr_ctrl: collects up to NSRC peripheral request lines, latches or follows
// each one, masks and prioritises them, and drives one registered CPU irq.
// Software access goes through the 2-bit AD/cs/rw peripheral bus.
module intr_ctrl #(
   parameter int unsigned NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      AD,
   input  logic [7:0]      DI,
   output logic [7:0]      DO,
   input  logic            rw,
   input  logic            cs,
   input  logic [NSRC-1:0] irq_in,
   output logic            irq
);

   // Bits above NSRC are tied off so unused sources always read 0.
   localparam logic [7:0] IMPL = 8'((9'd1 << NSRC) - 9'd1);

   logic [7:0] irq_ext;
   logic [7:0] s1, s2, s3;
   logic [7:0] pend, mask, edge_mode;
   logic [7:0] active, rise, clr, pend_nxt;
   logic [2:0] idx;
   logic       any, found, wr, ack;

   // Widen the request lines to the fixed 8-bit register width.
   always_comb begin
      irq_ext = '0;
      irq_ext[NSRC-1:0] = irq_in;
   end

   assign wr     = cs & ~rw;
   assign active = pend & mask;
   assign any    = |active;
   assign rise   = s2 & ~s3;
   assign ack    = wr && (AD == 2'd3) && DI[7] && any;

   // Lowest-numbered active source wins; idx stays 0 when nothing is active.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (active[i] && !found) begin
            idx   = 3'(i);
            found = 1'b1;
         end
      end
   end

   // Bits to clear this cycle: explicit write-1-to-clear on PEND, or ack of idx.
   // A new rising edge on the same bit overrides the clear (set wins).
   always_comb begin
      clr = '0;
      if (wr && (AD == 2'd0))
         clr = DI;
      if (ack)
         clr[idx] = 1'b1;
      pend_nxt = ((edge_mode & (rise | (pend & ~clr))) | (~edge_mode & s2)) & IMPL;
   end

   // Synchroniser, edge-detect delay, registers and the registered irq output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         pend      <= '0;
         mask      <= '0;
         edge_mode <= '0;
         irq       <= 1'b0;
      end else begin
         s1   <= irq_ext & IMPL;
         s2   <= s1;
         s3   <= s2;
         pend <= pend_nxt;
         irq  <= any;
         if (wr && (AD == 2'd1))
            mask <= DI & IMPL;
         if (wr && (AD == 2'd2))
            edge_mode <= DI & IMPL;
      end
   end

   // Read mux, combinational from AD.
   always_comb begin
      unique case (AD)
         2'd0:    DO = pend;
         2'd1:    DO = mask;
         2'd2:    DO = edge_mode;
         default: DO = {any, 4'b0000, idx};
      endcase
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: scoreboard bench for intr_ctrl. Inputs change on the falling
// edge; expectations are queued with each stimulus step and compared against
// the DUT on the falling edge, away from the active rising edge.
module tb_intr_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] AD;
   logic [7:0] DI;
   logic [7:0] DO;
   logic       rw;
   logic       cs;
   logic [7:0] irq_in;
   logic       irq;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];

   intr_ctrl #(.NSRC(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .AD     (AD),
      .DI     (DI),
      .DO     (DO),
      .rw     (rw),
      .cs     (cs),
      .irq_in (irq_in),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [7:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic sb_pop(input logic [7:0] got);
      sb_item_t it;
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 8'h01, 8'h00);
      end else begin
         it = sb_q.pop_front();
         chk(it.tag, got, it.exp);
      end
   endtask

   // Register read: queue the expected value, drive the address, compare DO.
   task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
      sb_push(tag, exp);
      AD = a;
      cs = 1'b1;
      rw = 1'b1;
      #1;
      sb_pop(DO);
      cs = 1'b0;
   endtask

   task automatic irq_is(input string tag, input logic exp);
      sb_push(tag, {7'b0, exp});
      #1;
      sb_pop({7'b0, irq});
   endtask

   // Write spanning exactly one rising edge; called and returns on a falling edge.
   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      AD = a;
      DI = d;
      cs = 1'b1;
      rw = 1'b0;
      @(negedge clk);
      cs = 1'b0;
      rw = 1'b1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; AD = '0; DI = '0; rw = 1'b1; cs = 1'b0; irq_in = 8'hFF;

      // 1: reset with all requests high
      cycles(3);
      irq_is("rst_irq", 1'b0);
      rd("rst_pend", 2'd0, 8'h00);
      rd("rst_mask", 2'd1, 8'h00);
      rd("rst_edge", 2'd2, 8'h00);
      rd("rst_vec",  2'd3, 8'h00);
      irq_in = 8'h00;
      rst = 1'b1;
      cycles(2);

      // 2: edge-mode latency on bit 0
      wr_reg(2'd1, 8'h01);
      wr_reg(2'd2, 8'h01);
      irq_in = 8'h01;
      cycles(1);                        // edge 1
      irq_in = 8'h00;
      cycles(1);                        // edge 2
      rd("lat_pend_e2", 2'd0, 8'h00);
      cycles(1);                        // edge 3
      rd("lat_pend_e3", 2'd0, 8'h01);
      irq_is("lat_irq_e3", 1'b0);
      cycles(1);                        // edge 4
      irq_is("lat_irq_e4", 1'b1);
      wr_reg(2'd0, 8'h01);
      rd("lat_clr_pend", 2'd0, 8'h00);
      irq_is("lat_clr_irq_hold", 1'b1);
      cycles(1);
      irq_is("lat_clr_irq", 1'b0);

      // 3: priority and ack
      wr_reg(2'd2, 8'hFF);
      wr_reg(2'd1, 8'hFF);
      irq_in = 8'h24;
      cycles(1);
      irq_in = 8'h00;
      cycles(4);
      rd("pri_pend", 2'd0, 8'h24);
      rd("pri_vec1", 2'd3, 8'h82);
      wr_reg(2'd3, 8'h80);
      rd("pri_vec2", 2'd3, 8'h85);
      wr_reg(2'd3, 8'h80);
      rd("pri_vec3", 2'd3, 8'h00);
      cycles(1);
      irq_is("pri_irq", 1'b0);
      wr_reg(2'd3, 8'hFF);
      rd("ack_idle_vec", 2'd3, 8'h00);
      rd("ack_idle_pend", 2'd0, 8'h00);

      // 4: level mode on bit 3
      wr_reg(2'd2, 8'h00);
      wr_reg(2'd1, 8'h08);
      irq_in = 8'h08;
      cycles(4);
      irq_is("lvl_irq", 1'b1);
      rd("lvl_pend", 2'd0, 8'h08);
      wr_reg(2'd0, 8'h08);
      rd("lvl_clr_ignored", 2'd0, 8'h08);
      irq_in = 8'h00;
      cycles(3);
      rd("lvl_drop_pend", 2'd0, 8'h00);
      cycles(1);
      irq_is("lvl_drop_irq", 1'b0);

      // 5: clear collides with a new edge on bit 0
      wr_reg(2'd2, 8'h01);
      wr_reg(2'd1, 8'h01);
      irq_in = 8'h01;
      cycles(1);
      irq_in = 8'h00;
      cycles(4);
      irq_is("col_pre_irq", 1'b1);
      irq_in = 8'h01;
      cycles(1);                        // edge 1
      irq_in = 8'h00;
      cycles(1);                        // edge 2
      wr_reg(2'd0, 8'h01);              // edge 3: rise and clear together
      rd("col_pend", 2'd0, 8'h01);
      cycles(1);
      irq_is("col_irq", 1'b1);
      wr_reg(2'd0, 8'h01);
      rd("col_clr_pend", 2'd0, 8'h00);
      cycles(1);
      irq_is("col_clr_irq", 1'b0);

      // 6: masked pending, then asynchronous reset
      wr_reg(2'd2, 8'h10);
      wr_reg(2'd1, 8'h00);
      irq_in = 8'h10;
      cycles(1);
      irq_in = 8'h00;
      cycles(4);
      irq_is("msk_irq0", 1'b0);
      rd("msk_pend", 2'd0, 8'h10);
      wr_reg(2'd1, 8'h10);
      cycles(1);
      irq_is("msk_irq1", 1'b1);
      #2 rst = 1'b0;
      irq_is("arst_irq", 1'b0);
      rd("arst_pend", 2'd0, 8'h00);
      rd("arst_mask", 2'd1, 8'h00);
      rd("arst_edge", 2'd2, 8'h00);
      rd("arst_vec",  2'd3, 8'h00);
      #1 rst = 1'b1;
      cycles(2);
      irq_is("post_rst_irq", 1'b0);
      rd("post_rst_pend", 2'd0, 8'h00);

      chk("sb_empty", 8'(sb_q.size()), 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
